// File: rtl/pipe_pkg.sv
// Shared types for the pipeline stage registers: stage occupancy states and
// the packed payloads carried between IF/ID/EX/MEM/WB.
package pipe_pkg;

  typedef enum logic [1:0] {
    PS_EMPTY     = 2'd0,
    PS_FULL      = 2'd1,
    PS_SKID_FULL = 2'd2
  } pipe_state_e;

  // addi x0, x0, 0: the canonical NOP used to build bubble payloads.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
    logic        reg_we;
    logic        mem_re;
    logic        mem_we;
  } id_ex_t;

  typedef struct packed {
    logic [31:0] alu_res;
    logic [31:0] store_val;
    logic [4:0]  rd;
    logic        reg_we;
    logic        mem_re;
    logic        mem_we;
  } ex_mem_t;

  typedef struct packed {
    logic [31:0] wb_val;
    logic [4:0]  rd;
    logic        reg_we;
  } mem_wb_t;

  localparam if_id_t IF_ID_NOP = '{pc: 32'h0, instr: NOP_INSTR};

endpackage

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, synchronous flush and
// an optional 2-entry skid buffer that registers the backward ready path.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned      WIDTH   = 32,
  parameter bit               SKID    = 1'b1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic [1:0]       count_o
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; a producer holds valid and data stable until it is accepted.

  pipe_state_e      state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= PS_EMPTY;
      main_q  <= RST_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
    end
  end

  assign valid_o = (state_q != PS_EMPTY);
  assign data_o  = main_q;

  always_comb begin
    count_o = 2'd0;
    case (state_q)
      PS_FULL:      count_o = 2'd1;
      PS_SKID_FULL: count_o = 2'd2;
      default:      count_o = 2'd0;
    endcase
  end

  if (SKID) begin : g_skid
    logic [WIDTH-1:0] skid_q, skid_d;

    always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) skid_q <= RST_VAL;
      else        skid_q <= skid_d;
    end

    // Ready depends on state only, so downstream stall logic never reaches
    // upstream combinationally; reset still forces it low immediately.
    assign ready_o = rst_i & (state_q != PS_SKID_FULL);

    always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush_i) begin
        state_d = PS_EMPTY;
        main_d  = RST_VAL;
        skid_d  = RST_VAL;
      end else begin
        case (state_q)
          PS_EMPTY: begin
            if (valid_i) begin
              state_d = PS_FULL;
              main_d  = data_i;
            end
          end
          PS_FULL: begin
            if (valid_i && ready_i) begin
              main_d = data_i;
            end else if (valid_i) begin
              state_d = PS_SKID_FULL;
              skid_d  = data_i;
            end else if (ready_i) begin
              state_d = PS_EMPTY;
            end
          end
          PS_SKID_FULL: begin
            if (ready_i) begin
              state_d = PS_FULL;
              main_d  = skid_q;
            end
          end
          default: state_d = PS_EMPTY;
        endcase
      end
    end
  end else begin : g_noskid
    logic up_xfer, dn_xfer;

    assign ready_o = rst_i & (!valid_o | ready_i);
    assign up_xfer = valid_i & ready_o;
    assign dn_xfer = valid_o & ready_i;

    always_comb begin
      state_d = state_q;
      main_d  = main_q;
      if (flush_i) begin
        state_d = PS_EMPTY;
        main_d  = RST_VAL;
      end else if (up_xfer) begin
        state_d = PS_FULL;
        main_d  = data_i;
      end else if (dn_xfer) begin
        state_d = PS_EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed table and sequences on 32-bit instances,
// plus random queue-model checks on 1-bit and 181-bit instances of both modes.
module tb_pipe_stage_reg;

  localparam int unsigned CW = 181;

  logic clk;
  logic rst_n;
  int   vecs;
  int   errs;
  bit   rnd_go;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Directed instance, SKID=1
  logic s1_fl, s1_vi, s1_ro, s1_vo, s1_ri;
  logic [31:0] s1_di, s1_do;
  logic [1:0]  s1_cnt;

  pipe_stage_reg #(.WIDTH(32), .SKID(1'b1)) u_s1 (
    .clk_i(clk), .rst_i(rst_n), .flush_i(s1_fl), .valid_i(s1_vi), .ready_o(s1_ro),
    .data_i(s1_di), .valid_o(s1_vo), .ready_i(s1_ri), .data_o(s1_do), .count_o(s1_cnt)
  );

  // Directed instance, SKID=0
  logic s0_fl, s0_vi, s0_ro, s0_vo, s0_ri;
  logic [31:0] s0_di, s0_do;
  logic [1:0]  s0_cnt;

  pipe_stage_reg #(.WIDTH(32), .SKID(1'b0)) u_s0 (
    .clk_i(clk), .rst_i(rst_n), .flush_i(s0_fl), .valid_i(s0_vi), .ready_o(s0_ro),
    .data_i(s0_di), .valid_o(s0_vo), .ready_i(s0_ri), .data_o(s0_do), .count_o(s0_cnt)
  );

  // Random instances: g=0 W1/SKID0, g=1 W1/SKID1, g=2 W181/SKID0, g=3 W181/SKID1
  for (genvar g = 0; g < 4; g++) begin : g_rnd
    localparam int unsigned W = (g < 2) ? 1 : CW;
    localparam bit          S = (g % 2 == 1);
    logic fl, vi, ro, vo, ri, done, exp_ro;
    logic [W-1:0] di, dout;
    logic [1:0]   cnt;
    logic [W-1:0] exp_q[$];

    pipe_stage_reg #(.WIDTH(W), .SKID(S)) u_dut (
      .clk_i(clk), .rst_i(rst_n), .flush_i(fl), .valid_i(vi), .ready_o(ro),
      .data_i(di), .valid_o(vo), .ready_i(ri), .data_o(dout), .count_o(cnt)
    );

    initial begin
      fl = 1'b0; vi = 1'b0; ri = 1'b0; di = '0; done = 1'b0; exp_ro = 1'b0;
      wait (rnd_go);
      for (int c = 0; c < 800; c++) begin
        @(negedge clk);
        vi = ($urandom_range(0, 3) != 0);
        ri = ($urandom_range(0, 2) != 0);
        fl = ($urandom_range(0, 99) < 5);
        for (int b = 0; b < W; b++) di[b] = 1'($urandom_range(0, 1));
        #1;
        exp_ro = S ? (exp_q.size() < 2) : (exp_q.size() == 0 || ri);
        chk($sformatf("rnd%0d_valid", g), CW'(vo), CW'(exp_q.size() != 0));
        chk($sformatf("rnd%0d_count", g), CW'(cnt), CW'(exp_q.size()));
        chk($sformatf("rnd%0d_ready", g), CW'(ro), CW'(exp_ro));
        if (fl) begin
          exp_q.delete();
        end else begin
          if (exp_q.size() != 0 && ri) begin
            chk($sformatf("rnd%0d_data", g), CW'(dout), CW'(exp_q[0]));
            void'(exp_q.pop_front());
          end
          if (vi && exp_ro) exp_q.push_back(di);
        end
      end
      done = 1'b1;
    end
  end

  typedef struct {
    logic        fl;
    logic        v;
    logic [31:0] d;
    logic        r;
    logic        ev;
    logic [31:0] ed;
    logic [1:0]  ec;
    logic        er;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic fl, input logic v, input logic [31:0] d, input logic r,
                     input logic ev, input logic [31:0] ed, input logic [1:0] ec, input logic er);
    vec_t t;
    t = '{fl: fl, v: v, d: d, r: r, ev: ev, ed: ed, ec: ec, er: er};
    tbl.push_back(t);
  endtask

  task automatic step_s1(input vec_t t);
    @(negedge clk);
    s1_fl = t.fl; s1_vi = t.v; s1_di = t.d; s1_ri = t.r;
    @(posedge clk);
    #1;
    chk("s1_valid", CW'(s1_vo), CW'(t.ev));
    chk("s1_data",  CW'(s1_do), CW'(t.ed));
    chk("s1_count", CW'(s1_cnt), CW'(t.ec));
    chk("s1_ready", CW'(s1_ro), CW'(t.er));
  endtask

  task automatic s0_drive(input logic fl, input logic v, input logic [31:0] d, input logic r);
    s0_fl = fl; s0_vi = v; s0_di = d; s0_ri = r;
  endtask

  initial begin
    vecs = 0; errs = 0; rnd_go = 1'b0;
    rst_n = 1'b0;
    s1_fl = 0; s1_vi = 0; s1_di = '0; s1_ri = 0;
    s0_drive(0, 0, '0, 0);
    #12;
    chk("rst_valid", CW'(s1_vo), CW'(0));
    chk("rst_count", CW'(s1_cnt), CW'(0));
    chk("rst_ready", CW'(s1_ro), CW'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_ready_s1", CW'(s1_ro), CW'(1));
    chk("rel_ready_s0", CW'(s0_ro), CW'(1));

    // streaming 1..8, then drain
    for (int k = 1; k <= 8; k++) add(0, 1, 32'(k), 1, 1, 32'(k), 1, 1);
    add(0, 0, 0, 1, 0, 8, 0, 1);
    // backpressure: 5 in main, 6 in skid, 3-cycle hold, release
    add(0, 1, 5, 1, 1, 5, 1, 1);
    add(0, 1, 6, 0, 1, 5, 2, 0);
    for (int k = 0; k < 3; k++) add(0, 1, 7, 0, 1, 5, 2, 0);
    add(0, 0, 0, 1, 1, 6, 1, 1);
    add(0, 0, 0, 1, 0, 6, 0, 1);
    // flush in SKID_FULL with a coincident payload 9
    add(0, 1, 10, 1, 1, 10, 1, 1);
    add(0, 1, 11, 0, 1, 10, 2, 0);
    add(1, 1, 9, 0, 0, 0, 0, 1);
    add(0, 1, 12, 1, 1, 12, 1, 1);
    add(0, 0, 0, 1, 0, 12, 0, 1);
    // reach SKID_FULL holding DEAD_BEEF for the mid-stream reset
    add(0, 1, 1, 1, 1, 1, 1, 1);
    add(0, 1, 32'hDEAD_BEEF, 0, 1, 1, 2, 0);
    for (int i = 0; i < tbl.size(); i++) step_s1(tbl[i]);

    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", CW'(s1_vo), CW'(0));
    chk("arst_count", CW'(s1_cnt), CW'(0));
    chk("arst_data",  CW'(s1_do), CW'(0));
    chk("arst_ready", CW'(s1_ro), CW'(0));
    @(negedge clk);
    s1_vi = 0; s1_ri = 0; s1_di = '0;
    rst_n = 1'b1;
    #1;
    chk("arel_ready", CW'(s1_ro), CW'(1));
    chk("arel_valid", CW'(s1_vo), CW'(0));

    // SKID=0 sequences
    @(negedge clk);
    s0_drive(0, 1, 32'hA, 1);
    #1 chk("s0_ready_empty", CW'(s0_ro), CW'(1));
    @(posedge clk);
    #1;
    chk("s0_fill_data", CW'(s0_do), CW'(32'hA));
    chk("s0_fill_count", CW'(s0_cnt), CW'(1));
    @(negedge clk);
    s0_drive(0, 0, 0, 0);
    #1 chk("s0_ready_stall", CW'(s0_ro), CW'(0));
    s0_drive(0, 1, 32'hB, 1);
    #1 chk("s0_ready_go", CW'(s0_ro), CW'(1));
    @(posedge clk);
    #1;
    chk("s0_pass_count", CW'(s0_cnt), CW'(1));
    chk("s0_pass_data", CW'(s0_do), CW'(32'hB));
    @(negedge clk);
    s0_drive(0, 1, 32'hC, 0);
    #1 chk("s0_ready_full", CW'(s0_ro), CW'(0));
    @(posedge clk);
    #1;
    chk("s0_hold_data", CW'(s0_do), CW'(32'hB));
    chk("s0_hold_count", CW'(s0_cnt), CW'(1));
    @(negedge clk);
    s0_drive(1, 1, 32'hD, 0);
    @(posedge clk);
    #1;
    chk("s0_flush_valid", CW'(s0_vo), CW'(0));
    chk("s0_flush_data", CW'(s0_do), CW'(0));
    chk("s0_flush_count", CW'(s0_cnt), CW'(0));
    @(negedge clk);
    s0_drive(0, 0, 0, 0);

    rnd_go = 1'b1;
    for (int t = 0; t < 2000; t++) begin
      if (g_rnd[0].done && g_rnd[1].done && g_rnd[2].done && g_rnd[3].done) break;
      @(posedge clk);
    end
    chk("rnd_finished", CW'(g_rnd[0].done && g_rnd[1].done && g_rnd[2].done && g_rnd[3].done), CW'(1));

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
